// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the shadow-result payload.
package mdu_ctrl_pkg;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned PROD_W         = 2 * DATA_W;
   localparam int unsigned OP_W           = 3;
   localparam int unsigned MUL_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF = 10;

   typedef enum logic [OP_W-1:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   // Result held while busy; wr clear means HI/LO stay untouched at completion.
   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              wr;
   } mdu_result_t;

   function automatic logic op_is_signed(input logic [OP_W-1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: signed/unsigned 32x32 multiply and divide.
// Signed divide works on magnitudes so MIN_INT / -1 wraps cleanly to MIN_INT.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [PROD_W-1:0] product,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_zero
);

   logic              sgn;
   logic              neg_a;
   logic              neg_b;
   logic [PROD_W-1:0] ext_a;
   logic [PROD_W-1:0] ext_b;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [DATA_W-1:0] den;
   logic [DATA_W-1:0] uq;
   logic [DATA_W-1:0] ur;

   always_comb begin
      sgn     = op_is_signed(op);
      neg_a   = sgn & a[DATA_W-1];
      neg_b   = sgn & b[DATA_W-1];

      // Truncated 64-bit product of extended operands is exact for both signednesses.
      ext_a   = {{DATA_W{neg_a}}, a};
      ext_b   = {{DATA_W{neg_b}}, b};
      product = ext_a * ext_b;

      mag_a    = neg_a ? (~a + DATA_W'(1)) : a;
      mag_b    = neg_b ? (~b + DATA_W'(1)) : b;
      div_zero = (b == '0);
      den      = div_zero ? DATA_W'(1) : mag_b;
      uq       = mag_a / den;
      ur       = mag_a % den;

      // Quotient truncates toward zero; remainder follows the dividend's sign.
      quotient  = (neg_a ^ neg_b) ? (~uq + DATA_W'(1)) : uq;
      remainder = neg_a ? (~ur + DATA_W'(1)) : ur;
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: accepts one operation at a time, holds the
// result in a shadow register for the fixed latency, then commits to HI/LO.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   mdu_state_e        state;
   mdu_state_e        state_nxt;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   mdu_result_t       shadow;
   mdu_result_t       shadow_nxt;
   logic [DATA_W-1:0] hi_nxt;
   logic [DATA_W-1:0] lo_nxt;
   logic              busy_nxt;

   logic [PROD_W-1:0] product;
   logic [DATA_W-1:0] quotient;
   logic [DATA_W-1:0] remainder;
   logic              div_zero;

   mdu_arith u_arith (
      .op        (op),
      .a         (a),
      .b         (b),
      .product   (product),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   // State and latency counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     state_nxt = ST_MUL;
                     count_nxt = CNT_W'(MUL_CYCLES);
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_nxt = ST_DIV;
                     count_nxt = CNT_W'(DIV_CYCLES);
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            count_nxt = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
         end
      endcase
   end

   // Shadow capture on accept, HI/LO commit on the final busy cycle.
   always_comb begin
      shadow_nxt = shadow;
      hi_nxt     = hi;
      lo_nxt     = lo;
      busy_nxt   = (state_nxt != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     shadow_nxt = '{hi: product[PROD_W-1:DATA_W],
                                    lo: product[DATA_W-1:0],
                                    wr: 1'b1};
                  end
                  MDU_DIV, MDU_DIVU: begin
                     shadow_nxt = '{hi: remainder, lo: quotient, wr: ~div_zero};
                  end
                  MDU_MTHI: hi_nxt = a;
                  MDU_MTLO: lo_nxt = a;
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            if ((count == CNT_W'(1)) && shadow.wr) begin
               hi_nxt = shadow.hi;
               lo_nxt = shadow.lo;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
      end else begin
         shadow <= shadow_nxt;
         hi     <= hi_nxt;
         lo     <= lo_nxt;
         busy   <= busy_nxt;
      end
   end

endmodule
